// File: rtl/datapath.sv
// datapath: 32-bit bus-oriented CPU datapath with a register file, special
// registers, a 64-bit Z result register and a 16-operation ALU.
// Optional feature: define DATAPATH_DIV_EN to include the signed divider;
// without it, ALU_op 0110 produces Z = 0.
module datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic [4:0]  BusDataSelect,
    input  logic [3:0]  GP_addr,
    input  logic [31:0] Mdatain,
    input  logic        MDR_read,
    input  logic [3:0]  ALU_op,
    input  logic        incPC,
    input  logic        e_PC,
    input  logic        e_IR,
    input  logic        e_Y,
    input  logic        e_MAR,
    input  logic        e_HI,
    input  logic        e_LO,
    input  logic        e_Z,
    input  logic        e_MDR,
    input  logic        e_GP,
    output logic [31:0] BusMuxOut,
    output logic [31:0] PC_q,
    output logic [31:0] MAR_q,
    output logic [31:0] IR_q,
    output logic [31:0] HI_q,
    output logic [31:0] LO_q
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_MUL   = 4'b0101,
        OP_DIV   = 4'b0110,
        OP_SHR   = 4'b0111,
        OP_SHRA  = 4'b1000,
        OP_SHL   = 4'b1001,
        OP_ROR   = 4'b1010,
        OP_ROL   = 4'b1011,
        OP_NEG   = 4'b1100,
        OP_NOT   = 4'b1101,
        OP_PASSA = 4'b1110,
        OP_PASSB = 4'b1111
    } alu_op_e;

    logic [31:0] pc_q, ir_q, y_q, mar_q, hi_q, lo_q, mdr_q;
    logic [63:0] z_q;
    logic [31:0] gp_regs [16];

    logic [31:0] bus;
    logic [63:0] alu_result;
    logic [63:0] div_result;
    logic [4:0]  amt;
    logic signed [63:0] a_ext, b_ext, product;

    // Bus source multiplexer: registers R0-R15, then special registers, else zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        bus = 32'h0;
        if (!BusDataSelect[4]) begin
            bus = gp_regs[BusDataSelect[3:0]];
        end else begin
            case (BusDataSelect[3:0])
                4'd0:    bus = hi_q;
                4'd1:    bus = lo_q;
                4'd2:    bus = z_q[63:32];
                4'd3:    bus = z_q[31:0];
                4'd4:    bus = pc_q;
                4'd5:    bus = mdr_q;
                default: bus = 32'h0;
            endcase
        end
    end

    assign amt     = bus[4:0];
    assign a_ext   = {{32{y_q[31]}}, y_q};
    assign b_ext   = {{32{bus[31]}}, bus};
    assign product = a_ext * b_ext;

`ifdef DATAPATH_DIV_EN
    logic [31:0] quotient, remainder;

    // Signed divide truncating toward zero; divide-by-zero returns A as the remainder.
    always_comb begin
        quotient  = 32'h0;
        remainder = y_q;
        if (bus != 32'h0) begin
            quotient  = $signed(y_q) / $signed(bus);
            remainder = $signed(y_q) % $signed(bus);
        end
    end

    assign div_result = {remainder, quotient};
`else
    assign div_result = 64'h0;
`endif

    // ALU: A = Y, B = bus; incPC overrides the opcode with bus + 1.
    always_comb begin
        alu_result = 64'h0;
        if (incPC) begin
            alu_result = {32'h0, bus + 32'd1};
        end else begin
            case (alu_op_e'(ALU_op))
                OP_ADD:  alu_result = {32'h0, y_q + bus};
                OP_SUB:  alu_result = {32'h0, y_q - bus};
                OP_AND:  alu_result = {32'h0, y_q & bus};
                OP_OR:   alu_result = {32'h0, y_q | bus};
                OP_XOR:  alu_result = {32'h0, y_q ^ bus};
                OP_MUL:  alu_result = product;
                OP_DIV:  alu_result = div_result;
                OP_SHR:  alu_result = {32'h0, y_q >> amt};
                OP_SHRA: alu_result = {32'h0, $signed(y_q) >>> amt};
                OP_SHL:  alu_result = {32'h0, y_q << amt};
                // A shift by 32 yields zero, so amount 0 needs no special case.
                OP_ROR:  alu_result = {32'h0, (y_q >> amt) | (y_q << (6'd32 - {1'b0, amt}))};
                OP_ROL:  alu_result = {32'h0, (y_q << amt) | (y_q >> (6'd32 - {1'b0, amt}))};
                OP_NEG:  alu_result = {32'h0, 32'h0 - bus};
                OP_NOT:  alu_result = {32'h0, ~bus};
                default: alu_result = {32'h0, bus};
            endcase
        end
    end

    // Register loads: clear wins over every enable; all loads sample the pre-edge bus/ALU.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so simultaneous loads all see pre-edge values.
        if (clear) begin
            pc_q  <= 32'h0;
            ir_q  <= 32'h0;
            y_q   <= 32'h0;
            mar_q <= 32'h0;
            hi_q  <= 32'h0;
            lo_q  <= 32'h0;
            mdr_q <= 32'h0;
            z_q   <= 64'h0;
            // NOTE: the register file is reset explicitly because clear must zero R0-R15, which rules out a RAM macro.
            for (int i = 0; i < 16; i++) begin
                gp_regs[i] <= 32'h0;
            end
        end else begin
            if (e_PC)  pc_q  <= bus;
            if (e_IR)  ir_q  <= bus;
            if (e_Y)   y_q   <= bus;
            if (e_MAR) mar_q <= bus;
            if (e_HI)  hi_q  <= bus;
            if (e_LO)  lo_q  <= bus;
            if (e_Z)   z_q   <= alu_result;
            if (e_MDR) mdr_q <= MDR_read ? Mdatain : bus;
            if (e_GP)  gp_regs[GP_addr] <= bus;
        end
    end

    assign BusMuxOut = bus;
    assign PC_q      = pc_q;
    assign MAR_q     = mar_q;
    assign IR_q      = ir_q;
    assign HI_q      = hi_q;
    assign LO_q      = lo_q;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: randomized and directed bench for datapath, compared against an
// arithmetic reference model. Honours DATAPATH_DIV_EN the same way as the design.
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [4:0]  BusDataSelect;
    logic [3:0]  GP_addr;
    logic [31:0] Mdatain;
    logic        MDR_read;
    logic [3:0]  ALU_op;
    logic        incPC;
    logic        e_PC, e_IR, e_Y, e_MAR, e_HI, e_LO, e_Z, e_MDR, e_GP;
    logic [31:0] BusMuxOut, PC_q, MAR_q, IR_q, HI_q, LO_q;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_y, m_mar, m_hi, m_lo, m_mdr;
    logic [63:0] m_z;

    datapath dut (
        .clock(clock), .clear(clear), .BusDataSelect(BusDataSelect), .GP_addr(GP_addr),
        .Mdatain(Mdatain), .MDR_read(MDR_read), .ALU_op(ALU_op), .incPC(incPC),
        .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_MAR(e_MAR), .e_HI(e_HI), .e_LO(e_LO),
        .e_Z(e_Z), .e_MDR(e_MDR), .e_GP(e_GP),
        .BusMuxOut(BusMuxOut), .PC_q(PC_q), .MAR_q(MAR_q), .IR_q(IR_q), .HI_q(HI_q), .LO_q(LO_q)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model_bus(input logic [4:0] sel);
        if (sel < 5'd16) return m_r[sel[3:0]];
        case (sel)
            5'd16:   return m_hi;
            5'd17:   return m_lo;
            5'd18:   return m_z[63:32];
            5'd19:   return m_z[31:0];
            5'd20:   return m_pc;
            5'd21:   return m_mdr;
            default: return 32'h0;
        endcase
    endfunction

    // ALU computed with plain integer arithmetic on 64-bit values.
    function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic inc);
        longint unsigned ua, ub, p2, m32;
        longint sa, sb;
        int n, q, r;
        logic [31:0] r32;
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        m32 = 64'h1_0000_0000;
        n   = int'(b[4:0]);
        p2  = 1;
        for (int i = 0; i < n; i++) p2 = p2 * 2;
        if (inc) return {32'h0, 32'((ub + 1) % m32)};
        case (op)
            4'd0:  r32 = 32'((ua + ub) % m32);
            4'd1:  r32 = 32'((ua + m32 - ub) % m32);
            4'd2:  r32 = a & b;
            4'd3:  r32 = a | b;
            4'd4:  r32 = a ^ b;
            4'd5:  return 64'(sa * sb);
            4'd6: begin
`ifdef DATAPATH_DIV_EN
                if (b == 32'h0) return {a, 32'h0};
                q = int'(a) / int'(b);
                r = int'(a) % int'(b);
                return {32'(r), 32'(q)};
`else
                q = 0;
                r = 0;
                return 64'(q + r);
`endif
            end
            4'd7:  r32 = 32'(ua / p2);
            4'd8:  begin
                if (sa >= 0) r32 = 32'(sa / longint'(p2));
                else         r32 = 32'(-((-sa + longint'(p2) - 1) / longint'(p2)));
            end
            4'd9:  r32 = 32'((ua * p2) % m32);
            4'd10: r32 = 32'(ua / p2 + (ua % p2) * (m32 / p2));
            4'd11: r32 = 32'((ua * p2) % m32 + ua / (m32 / p2));
            4'd12: r32 = 32'((m32 - ub) % m32);
            4'd13: r32 = 32'(ub ^ 64'hFFFF_FFFF);
            default: r32 = b;
        endcase
        return {32'h0, r32};
    endfunction

    task automatic set_idle();
        clear = 1'b0; BusDataSelect = 5'd22; GP_addr = 4'd0; Mdatain = 32'h0;
        MDR_read = 1'b0; ALU_op = 4'd0; incPC = 1'b0;
        e_PC = 1'b0; e_IR = 1'b0; e_Y = 1'b0; e_MAR = 1'b0; e_HI = 1'b0;
        e_LO = 1'b0; e_Z = 1'b0; e_MDR = 1'b0; e_GP = 1'b0;
    endtask

    // One clock: check the pre-edge bus, then advance the model with the current controls.
    task automatic step();
        logic [31:0] bv;
        logic [63:0] av;
        bv = model_bus(BusDataSelect);
        av = model_alu(ALU_op, m_y, bv, incPC);
        #1;
        n_checks++;
        if (BusMuxOut !== bv) begin
            n_fail++;
            $display("FAIL bus_pre_edge sel=%0d got %h expected %h", BusDataSelect, BusMuxOut, bv);
        end
        @(posedge clock);
        if (clear) begin
            m_pc = 0; m_ir = 0; m_y = 0; m_mar = 0; m_hi = 0; m_lo = 0; m_mdr = 0; m_z = 0;
            for (int i = 0; i < 16; i++) m_r[i] = 0;
        end else begin
            if (e_PC)  m_pc  = bv;
            if (e_IR)  m_ir  = bv;
            if (e_Y)   m_y   = bv;
            if (e_MAR) m_mar = bv;
            if (e_HI)  m_hi  = bv;
            if (e_LO)  m_lo  = bv;
            if (e_Z)   m_z   = av;
            if (e_MDR) m_mdr = MDR_read ? Mdatain : bv;
            if (e_GP)  m_r[GP_addr] = bv;
        end
        @(negedge clock);
        set_idle();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        Mdatain = v; MDR_read = 1'b1; e_MDR = 1'b1;
        step();
    endtask

    task automatic write_gp(input logic [3:0] addr, input logic [31:0] v);
        mdr_load(v);
        BusDataSelect = 5'd21; GP_addr = addr; e_GP = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear = 1'b1;
        step();
        n_checks++;
        if ({PC_q, MAR_q, IR_q, HI_q, LO_q} !== 160'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h %h %h %h %h expected all 0", PC_q, MAR_q, IR_q, HI_q, LO_q);
        end
        for (int s = 0; s < 32; s++) begin
            BusDataSelect = 5'(s);
            #1;
            n_checks++;
            if (BusMuxOut !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_bus sel=%0d got %h expected 0", s, BusMuxOut);
            end
        end
        @(negedge clock);
        set_idle();
    endtask

    task automatic test_div_example();
        logic [31:0] exp_lo, exp_hi;
`ifdef DATAPATH_DIV_EN
        exp_lo = 32'd1; exp_hi = 32'd2;
`else
        exp_lo = 32'd0; exp_hi = 32'd0;
`endif
        write_gp(4'd2, 32'd6);
        write_gp(4'd6, 32'd4);
        BusDataSelect = 5'd2; e_Y = 1'b1; step();
        BusDataSelect = 5'd6; ALU_op = 4'b0110; e_Z = 1'b1; step();
        BusDataSelect = 5'd19; e_LO = 1'b1; step();
        BusDataSelect = 5'd18; e_HI = 1'b1; step();
        n_checks++;
        if (LO_q !== exp_lo || HI_q !== exp_hi) begin
            n_fail++;
            $display("FAIL div_example LO/HI got %h/%h expected %h/%h", LO_q, HI_q, exp_lo, exp_hi);
        end
    endtask

    task automatic test_fetch();
        BusDataSelect = 5'd22; e_PC = 1'b1; step();
        BusDataSelect = 5'd20; e_MAR = 1'b1; incPC = 1'b1; e_Z = 1'b1; step();
        BusDataSelect = 5'd19; e_PC = 1'b1; MDR_read = 1'b1; e_MDR = 1'b1; Mdatain = 32'h2A37_0000; step();
        BusDataSelect = 5'd21; e_IR = 1'b1; step();
        n_checks++;
        if (MAR_q !== 32'h0 || PC_q !== 32'h1 || IR_q !== 32'h2A37_0000) begin
            n_fail++;
            $display("FAIL fetch MAR/PC/IR got %h/%h/%h expected 0/1/2a370000", MAR_q, PC_q, IR_q);
        end
    endtask

    // Z is read back through the bus (selects 18/19).
    task automatic test_mul_div_signed();
        logic [31:0] exp_lo, exp_hi;
        mdr_load(32'hFFFF_FFFA);
        BusDataSelect = 5'd21; e_Y = 1'b1; step();
        mdr_load(32'd4);
        BusDataSelect = 5'd21; ALU_op = 4'b0101; e_Z = 1'b1; step();
        BusDataSelect = 5'd18; #1;
        n_checks++;
        if (BusMuxOut !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL mul_zhigh got %h expected ffffffff", BusMuxOut);
        end
        BusDataSelect = 5'd19; #1;
        n_checks++;
        if (BusMuxOut !== 32'hFFFF_FFE8) begin
            n_fail++; $display("FAIL mul_zlow got %h expected ffffffe8", BusMuxOut);
        end
        @(negedge clock); set_idle();

        mdr_load(32'hFFFF_FFF9);
        BusDataSelect = 5'd21; e_Y = 1'b1; step();
        mdr_load(32'd2);
        BusDataSelect = 5'd21; ALU_op = 4'b0110; e_Z = 1'b1; step();
`ifdef DATAPATH_DIV_EN
        exp_lo = 32'hFFFF_FFFD; exp_hi = 32'hFFFF_FFFF;
`else
        exp_lo = 32'h0; exp_hi = 32'h0;
`endif
        BusDataSelect = 5'd19; #1;
        n_checks++;
        if (BusMuxOut !== exp_lo) begin
            n_fail++; $display("FAIL div_neg_zlow got %h expected %h", BusMuxOut, exp_lo);
        end
        BusDataSelect = 5'd18; #1;
        n_checks++;
        if (BusMuxOut !== exp_hi) begin
            n_fail++; $display("FAIL div_neg_zhigh got %h expected %h", BusMuxOut, exp_hi);
        end
        @(negedge clock); set_idle();

        BusDataSelect = 5'd22; ALU_op = 4'b0110; e_Z = 1'b1; step();
`ifdef DATAPATH_DIV_EN
        exp_hi = 32'hFFFF_FFF9;
`else
        exp_hi = 32'h0;
`endif
        BusDataSelect = 5'd19; #1;
        n_checks++;
        if (BusMuxOut !== 32'h0) begin
            n_fail++; $display("FAIL div_zero_zlow got %h expected 0", BusMuxOut);
        end
        BusDataSelect = 5'd18; #1;
        n_checks++;
        if (BusMuxOut !== exp_hi) begin
            n_fail++; $display("FAIL div_zero_zhigh got %h expected %h", BusMuxOut, exp_hi);
        end
        @(negedge clock); set_idle();
    endtask

    task automatic test_boundaries();
        // incPC wraps all-ones to zero with a zero upper half.
        mdr_load(32'hFFFF_FFFF);
        BusDataSelect = 5'd21; incPC = 1'b1; ALU_op = 4'b0101; e_Z = 1'b1; step();
        BusDataSelect = 5'd19; #1;
        n_checks++;
        if (BusMuxOut !== 32'h0) begin
            n_fail++; $display("FAIL incpc_wrap got %h expected 0", BusMuxOut);
        end
        @(negedge clock); set_idle();
        // Shift/rotate amounts 0 and 31 on a pattern with both end bits set.
        mdr_load(32'h8000_0001);
        BusDataSelect = 5'd21; e_Y = 1'b1; step();
        for (int op = 7; op <= 11; op++) begin
            for (int k = 0; k < 2; k++) begin
                mdr_load(k == 0 ? 32'd0 : 32'hFFFF_FFDF);
                BusDataSelect = 5'd21; ALU_op = 4'(op); e_Z = 1'b1; step();
                BusDataSelect = 5'd19; #1;
                n_checks++;
                if (BusMuxOut !== m_z[31:0] || m_z[63:32] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL shift_edge op=%0d k=%0d got %h expected %h", op, k, BusMuxOut, m_z[31:0]);
                end
                @(negedge clock); set_idle();
            end
        end
    endtask

    task automatic test_simultaneous_and_clear();
        write_gp(4'd5, 32'h0000_1234);
        mdr_load(32'd3);
        BusDataSelect = 5'd21; e_Y = 1'b1; step();
        BusDataSelect = 5'd5; ALU_op = 4'b0000; GP_addr = 4'd9;
        e_PC = 1; e_IR = 1; e_Y = 1; e_MAR = 1; e_HI = 1; e_LO = 1; e_Z = 1; e_MDR = 1; e_GP = 1;
        step();
        n_checks++;
        if ({PC_q, MAR_q, IR_q, HI_q, LO_q} !== {5{32'h0000_1234}}) begin
            n_fail++;
            $display("FAIL simultaneous_regs got %h %h %h %h %h expected 1234", PC_q, MAR_q, IR_q, HI_q, LO_q);
        end
        BusDataSelect = 5'd19; #1;
        n_checks++;
        if (BusMuxOut !== 32'h0000_1237) begin
            n_fail++; $display("FAIL simultaneous_z got %h expected 1237", BusMuxOut);
        end
        BusDataSelect = 5'd9; #1;
        n_checks++;
        if (BusMuxOut !== 32'h0000_1234) begin
            n_fail++; $display("FAIL simultaneous_gp got %h expected 1234", BusMuxOut);
        end
        @(negedge clock); set_idle();
        // Clear with every enable active: loads are discarded, bus stays live until the edge.
        clear = 1'b1; BusDataSelect = 5'd5; MDR_read = 1'b1; Mdatain = 32'hDEAD_BEEF; GP_addr = 4'd3;
        e_PC = 1; e_IR = 1; e_Y = 1; e_MAR = 1; e_HI = 1; e_LO = 1; e_Z = 1; e_MDR = 1; e_GP = 1;
        step();
        n_checks++;
        if ({PC_q, MAR_q, IR_q, HI_q, LO_q} !== 160'h0) begin
            n_fail++; $display("FAIL clear_mid_outputs got %h %h %h %h %h expected 0", PC_q, MAR_q, IR_q, HI_q, LO_q);
        end
        for (int s = 0; s < 22; s++) begin
            BusDataSelect = 5'(s); #1;
            n_checks++;
            if (BusMuxOut !== 32'h0) begin
                n_fail++; $display("FAIL clear_mid_bus sel=%0d got %h expected 0", s, BusMuxOut);
            end
        end
        @(negedge clock); set_idle();
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            BusDataSelect = 5'($urandom_range(0, 31));
            GP_addr  = 4'($urandom_range(0, 15));
            Mdatain  = $urandom;
            MDR_read = 1'($urandom_range(0, 1));
            ALU_op   = 4'($urandom_range(0, 15));
            incPC    = ($urandom_range(0, 7) == 0);
            clear    = ($urandom_range(0, 60) == 0);
            e_PC  = ($urandom_range(0, 3) == 0); e_IR = ($urandom_range(0, 3) == 0);
            e_Y   = ($urandom_range(0, 1) == 0); e_MAR = ($urandom_range(0, 3) == 0);
            e_HI  = ($urandom_range(0, 3) == 0); e_LO = ($urandom_range(0, 3) == 0);
            e_Z   = ($urandom_range(0, 1) == 0); e_MDR = ($urandom_range(0, 1) == 0);
            e_GP  = ($urandom_range(0, 1) == 0);
            step();
            n_checks++;
            if ({PC_q, MAR_q, IR_q, HI_q, LO_q} !== {m_pc, m_mar, m_ir, m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL random_regs it=%0d got %h %h %h %h %h expected %h %h %h %h %h", it,
                         PC_q, MAR_q, IR_q, HI_q, LO_q, m_pc, m_mar, m_ir, m_hi, m_lo);
            end
        end
        for (int s = 0; s < 32; s++) begin
            BusDataSelect = 5'(s); #1;
            n_checks++;
            if (BusMuxOut !== model_bus(5'(s))) begin
                n_fail++; $display("FAIL random_bus_sweep sel=%0d got %h expected %h", s, BusMuxOut, model_bus(5'(s)));
            end
        end
        @(negedge clock); set_idle();
    endtask

    initial begin
        set_idle();
        @(negedge clock);
        test_reset();
        test_div_example();
        test_fetch();
        test_mul_div_signed();
        test_boundaries();
        test_simultaneous_and_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port BusDataSelect, input, 5 bits: bus source select.
REQ-004 SHALL have port GP_addr, input, 4 bits: general register R0-R15 index for write.
REQ-005 SHALL have port Mdatain, input, 32 bits: memory read data.
REQ-006 SHALL have port MDR_read, input, 1 bit: MDR loads Mdatain (1) or bus (0).
REQ-007 SHALL have port ALU_op, input, 4 bits: ALU operation code.
REQ-008 SHALL have port incPC, input, 1 bit: ALU forced to compute bus+1.
REQ-009 SHALL have ports e_PC, e_IR, e_Y, e_MAR, e_HI, e_LO, input, 1 bit each: load the named 32-bit register from bus.
REQ-010 SHALL have port e_Z, input, 1 bit: load 64-bit Z from ALU result.
REQ-011 SHALL have port e_MDR, input, 1 bit: load MDR.
REQ-012 SHALL have port e_GP, input, 1 bit: load R[GP_addr] from bus.
REQ-013 SHALL have port BusMuxOut, output, 32 bits: current bus value (combinational).
REQ-014 SHALL have ports PC_q, MAR_q, IR_q, HI_q, LO_q, output, 32 bits each: register contents.

Function
REQ-015 SHALL drive the bus by BusDataSelect: 0-15 = R0-R15; 16 = HI; 17 = LO; 18 = Z[63:32]; 19 = Z[31:0]; 20 = PC; 21 = MDR; 22-31 = 32'h0.
REQ-016 SHALL use ALU operands A = Y and B = bus; result is 64 bits written to Z when e_Z=1.
REQ-017 SHALL decode ALU_op: 0000 ADD, 0001 SUB (A-B), 0010 AND, 0011 OR, 0100 XOR, 0101 MUL, 0110 DIV, 0111 SHR, 1000 SHRA, 1001 SHL, 1010 ROR, 1011 ROL, 1100 NEG(B), 1101 NOT(B), 1110-1111 pass B.
REQ-018 SHALL, for all ops except MUL/DIV, place the 32-bit result in Z[31:0] with Z[63:32] = 0; shift/rotate amount = B[4:0]; ADD/SUB wrap modulo 2^32.
REQ-019 SHALL compute MUL as signed 32x32 into the full 64-bit Z.
REQ-020 SHALL compute DIV as signed, truncating toward zero: Z[31:0] = quotient, Z[63:32] = remainder (sign of A).
REQ-021 SHALL, on DIV with B = 0, set Z[31:0] = 32'h0 and Z[63:32] = A.
REQ-022 SHALL, when incPC=1, override ALU_op so Z = {32'h0, bus+1}; wrap 32'hFFFFFFFF to 0.
REQ-023 SHALL load MDR with Mdatain when e_MDR=1 and MDR_read=1, and with the bus when e_MDR=1 and MDR_read=0.
REQ-024 SHALL leave every register unchanged when its enable is 0; R0 is an ordinary writable register.
REQ-025 SHALL complete every register load in one cycle; the loaded value is visible on outputs and bus the next cycle.
REQ-026 SHALL allow simultaneous enables; each enabled register samples the same pre-edge bus or ALU value.

Reset
REQ-027 SHALL, on rising clock with clear=1, zero PC, IR, MAR, MDR, Y, Z, HI, LO and R0-R15; clear has priority over all enables.
REQ-028 SHALL, when clear is asserted mid-operation, discard that cycle's loads; BusMuxOut stays combinational.

Configuration
REQ-029 SHALL, with macro DATAPATH_DIV_EN defined, include the divider per REQ-020/021.
REQ-030 SHALL, without DATAPATH_DIV_EN, make ALU_op 0110 yield Z = 64'h0; all other ops are unaffected.

Verification
REQ-031 SHALL pass: R2=6, R6=4 loaded via MDR then bus; Y<=R2; DIV with bus=R6; Zlow->LO, Zhigh->HI -> LO=1, HI=2.
REQ-032 SHALL pass: PC=0; PC out with e_MAR, incPC, e_Z; then Zlow->PC with MDR_read, Mdatain=32'h2A370000; then MDR->IR -> MAR=0, PC=1, IR=32'h2A370000.
REQ-033 SHALL pass: Y=-6 (32'hFFFFFFFA), bus=4, MUL -> Z=64'hFFFFFFFF_FFFFFFE8.
REQ-034 SHALL pass: Y=-7, bus=2, DIV -> Zlow=32'hFFFFFFFD, Zhigh=32'hFFFFFFFF; with bus=0 -> Zlow=0, Zhigh=32'hFFFFFFF9.
REQ-035 SHALL pass: clear=1 for one edge after nonzero loads -> all outputs 0, and BusMuxOut=0 for selects 0-21.
